// File: rtl/tile_pkg.sv
// Shared types and defaults for the tile fetch scheduler: tile geometry,
// sprite code type and the line-sequencing FSM encoding.
package tile_pkg;

  localparam int TILE_W      = 8;
  localparam int H_TILES_DEF = 80;
  localparam int V_TILES_DEF = 60;

  typedef logic [3:0] sprite_code_t;

  typedef enum logic [2:0] {
    S_BLANK     = 3'd0,
    S_PRE       = 3'd1,
    S_WAIT      = 3'd2,
    S_BLANK_RDY = 3'd3,
    S_ACTIVE    = 3'd4
  } tile_state_e;

endpackage

// File: rtl/tile_wr_arb.sv
// Tile-map RAM port mux: renderer reads always win, game-logic writes take free cycles.
// Build option TILE_FETCH_VBLANK_WR_ONLY_EN restricts write grants to vblank.
module tile_wr_arb
  import tile_pkg::*;
#(
  parameter int H_TILES = H_TILES_DEF,
  parameter int V_TILES = V_TILES_DEF,
  parameter int ADDR_W  = 13
) (
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              vblank,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_code,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  output logic              ram_we,
  output logic [3:0]        ram_wdata,
  output logic              wr_ack
);

  localparam logic [ADDR_W:0] MAP_SIZE = (ADDR_W+1)'(H_TILES * V_TILES);

  logic         wr_open;
  logic         in_range;
  sprite_code_t wcode;

`ifdef TILE_FETCH_VBLANK_WR_ONLY_EN
  assign wr_open = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign wr_open = 1'b1;
`endif

  assign in_range = ({1'b0, wr_addr} < MAP_SIZE);
  assign wcode    = wr_code;

  // Out-of-range writes are still acked so the requester never stalls.
  always_comb begin
    ram_addr  = '0;
    ram_rd_en = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    if (!rst) begin
      if (rd_req) begin
        ram_rd_en = 1'b1;
        ram_addr  = rd_addr;
      end else if (wr_req && wr_open) begin
        wr_ack    = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = wcode;
        ram_we    = in_range;
      end
    end
  end

endmodule

// File: rtl/tile_fetch_sched.sv
// Tile fetch scheduler: prefetches tile codes one tile ahead of the beam and
// feeds sprite_code / in-tile x,y to the sprite decoder. Option: TILE_FETCH_VBLANK_WR_ONLY_EN.
//
// state       | meaning
// S_BLANK     | idle between lines
// S_PRE       | read tile 0 of the upcoming row
// S_WAIT      | capture tile 0 code into next_code
// S_BLANK_RDY | first tile ready, waiting for de
// S_ACTIVE    | displaying, fetching tile n+1 at in-tile x==6
module tile_fetch_sched
  import tile_pkg::*;
#(
  parameter int H_TILES = H_TILES_DEF,
  parameter int V_TILES = V_TILES_DEF,
  parameter int ADDR_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        sx_in,
  input  logic [9:0]        sy_in,
  input  logic              de,
  input  logic              vblank,
  input  logic              line_start,
  input  logic [9:0]        next_y,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  output logic              ram_we,
  output logic [3:0]        ram_wdata,
  input  logic [3:0]        ram_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_code,
  output logic              wr_ack,
  output logic [2:0]        px_o,
  output logic [2:0]        py_o,
  output logic [3:0]        code_o,
  output logic              valid_o
);

  localparam logic [6:0] LAST_TILE = 7'(H_TILES - 1);

  tile_state_e       state, state_nxt;
  logic [6:0]        row_r;
  logic [6:0]        tile;
  logic [ADDR_W-1:0] row_base;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_pend;
  sprite_code_t      next_code, cur_code;
  logic [9:0]        unused_bits;

  assign unused_bits = {next_y[2:0], sy_in[9:3]};
  assign tile        = sx_in[9:3];
  assign row_base    = ADDR_W'(row_r) * ADDR_W'(H_TILES);

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    rd_addr   = '0;
    case (state)
      S_BLANK: state_nxt = S_BLANK;
      S_PRE: begin
        rd_req    = 1'b1;
        rd_addr   = row_base;
        state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_BLANK_RDY;
      S_BLANK_RDY: if (de) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (!de) begin
          state_nxt = S_BLANK;
        end else if (sx_in[2:0] == 3'd6 && tile < LAST_TILE) begin
          rd_req  = 1'b1;
          rd_addr = row_base + ADDR_W'(tile) + ADDR_W'(1);
        end
      end
      default: state_nxt = S_BLANK;
    endcase
    if (line_start) state_nxt = S_PRE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_BLANK;
      row_r     <= '0;
      rd_pend   <= 1'b0;
      next_code <= '0;
      cur_code  <= '0;
      px_o      <= '0;
      py_o      <= '0;
      code_o    <= '0;
      valid_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= ram_rd_en;
      valid_o <= de;
      px_o    <= sx_in[2:0];
      py_o    <= sy_in[2:0];
      if (line_start) row_r <= next_y[9:3];
      if (rd_pend) next_code <= ram_rdata;
      // First pixel of a tile takes next_code directly; cur_code catches up the same edge.
      if (de) begin
        if (sx_in[2:0] == 3'd0) begin
          cur_code <= next_code;
          code_o   <= next_code;
        end else begin
          code_o <= cur_code;
        end
      end
    end
  end

  tile_wr_arb #(
    .H_TILES(H_TILES),
    .V_TILES(V_TILES),
    .ADDR_W (ADDR_W)
  ) u_arb (
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .vblank   (vblank),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_code  (wr_code),
    .ram_addr (ram_addr),
    .ram_rd_en(ram_rd_en),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .wr_ack   (wr_ack)
  );

endmodule

// File: tb/tb_tile_fetch_sched.sv
// Bench for tile_fetch_sched: directed line scenarios plus randomized frames
// checked against a tile-map model of what each displayed pixel should show.
module tb_tile_fetch_sched;

  localparam int H   = 80;
  localparam int V   = 60;
  localparam int AW  = 13;
  localparam int MAP = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    sx_in, sy_in, next_y;
  logic          de, vblank, line_start;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en, ram_we;
  logic [3:0]    ram_wdata, ram_rdata;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_code;
  logic          wr_ack;
  logic [2:0]    px_o, py_o;
  logic [3:0]    code_o;
  logic          valid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_fetch_sched #(.H_TILES(H), .V_TILES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .sx_in(sx_in), .sy_in(sy_in), .de(de), .vblank(vblank),
    .line_start(line_start), .next_y(next_y), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_code(wr_code), .wr_ack(wr_ack), .px_o(px_o), .py_o(py_o),
    .code_o(code_o), .valid_o(valid_o)
  );

  // Tile-map RAM: unwritten locations return a seeded pattern, 1-cycle read latency.
  int unsigned seed;
  logic [3:0]  ram_mem [0:8191];
  bit          ram_wv  [0:8191];

  function automatic logic [3:0] init_val(input int a);
    return 4'((a * 13 + int'(seed)) ^ (a >> 4));
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_wv[ram_addr]  <= 1'b1;
    end
    if (ram_rd_en) ram_rdata <= ram_wv[ram_addr] ? ram_mem[ram_addr] : init_val(int'(ram_addr));
  end

  // Reference tile map: what game logic believes the map holds.
  logic [3:0] ref_mem [0:8191];
  bit         ref_wv  [0:8191];

  function automatic logic [3:0] ref_val(input int a);
    return ref_wv[a] ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    bit         ls;
    bit         de;
    bit         vb;
    logic [9:0] sx;
    logic [9:0] sy;
    logic [9:0] ny;
    int         prot;
  } cyc_t;

  task automatic test_reset();
    rst = 1'b1; de = 1'b1; sx_in = 10'd6; sy_in = 10'd0; vblank = 1'b0;
    line_start = 1'b0; next_y = '0; wr_req = 1'b1; wr_addr = 13'd3; wr_code = 4'd7;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_o, code_o, px_o, py_o} !== 11'd0) begin
      errors++; $display("FAIL reset_regs got %h want 0", {valid_o, code_o, px_o, py_o});
    end
    checks++;
    if ({ram_rd_en, ram_we, wr_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_port got %b want 000", {ram_rd_en, ram_we, wr_ack});
    end
    de = 1'b0; sx_in = '0; wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_free();
    int         wa[5] = '{160, 161, 239, 5, 5000};
    logic [3:0] wc[5] = '{4'h9, 4'hA, 4'hC, 4'h3, 4'h1};
    vblank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_req = 1'b1; wr_addr = AW'(wa[i]); wr_code = wc[i];
      #1;
      checks++;
      if (wr_ack !== 1'b1 || ram_rd_en !== 1'b0) begin
        errors++; $display("FAIL wr_free_ack[%0d] got ack=%b rd=%b want 1 0", i, wr_ack, ram_rd_en);
      end
      checks++;
      if (ram_we !== (wa[i] < MAP)) begin
        errors++; $display("FAIL wr_free_we[%0d] got %b want %b", i, ram_we, wa[i] < MAP);
      end
      if (wa[i] < MAP) begin
        checks++;
        if (ram_addr !== AW'(wa[i]) || ram_wdata !== wc[i]) begin
          errors++; $display("FAIL wr_free_bus[%0d] got %0d/%h want %0d/%h", i, ram_addr, ram_wdata, wa[i], wc[i]);
        end
        ref_mem[wa[i]] = wc[i]; ref_wv[wa[i]] = 1'b1;
      end
    end
    @(negedge clk);
    wr_req = 1'b0; vblank = 1'b0;
  endtask

  task automatic test_prefetch_fetch();
    @(negedge clk);
    line_start = 1'b1; next_y = 10'd16;
    @(negedge clk);
    line_start = 1'b0;
    #1;
    checks++;
    if (ram_rd_en !== 1'b1 || ram_addr !== 13'd160) begin
      errors++; $display("FAIL prefetch got rd=%b addr=%0d want 1 160", ram_rd_en, ram_addr);
    end
    repeat (2) @(negedge clk);
    de = 1'b1; sx_in = 10'd0; sy_in = 10'd16;
    for (int sx = 1; sx <= 9; sx++) begin
      @(negedge clk);
      checks++;
      if ({valid_o, px_o, py_o, code_o} !== {1'b1, 3'(sx - 1), 3'd0, (sx - 1 < 8) ? 4'h9 : 4'hA}) begin
        errors++; $display("FAIL first_tiles sx=%0d got v=%b px=%0d py=%0d code=%h", sx - 1, valid_o, px_o, py_o, code_o);
      end
      sx_in = 10'(sx);
      if (sx == 6) begin
        wr_req = 1'b1; wr_addr = 13'd5; wr_code = 4'hF;
      end
      if (sx == 8) wr_req = 1'b0;
      #1;
      if (sx == 6) begin
        checks++;
        if (ram_rd_en !== 1'b1 || ram_addr !== 13'd161 || wr_ack !== 1'b0 || ram_we !== 1'b0) begin
          errors++; $display("FAIL fetch_161 got rd=%b addr=%0d ack=%b we=%b want 1 161 0 0", ram_rd_en, ram_addr, wr_ack, ram_we);
        end
      end
      if (sx == 7) begin
        checks++;
`ifdef TILE_FETCH_VBLANK_WR_ONLY_EN
        if (wr_ack !== 1'b0 || ram_we !== 1'b0) begin
          errors++; $display("FAIL wr_gated got ack=%b we=%b want 0 0", wr_ack, ram_we);
        end
`else
        if ({wr_ack, ram_we, ram_rd_en} !== 3'b110 || ram_addr !== 13'd5 || ram_wdata !== 4'hF) begin
          errors++; $display("FAIL wr_deferred got ack=%b we=%b addr=%0d data=%h want 1 1 5 F", wr_ack, ram_we, ram_addr, ram_wdata);
        end
        ref_mem[5] = 4'hF; ref_wv[5] = 1'b1;
`endif
      end
    end
  endtask

  task automatic test_last_tile();
    for (int sx = 10; sx < 640; sx++) begin
      @(negedge clk);
      sx_in = 10'(sx);
      #1;
      checks++;
      if (ram_rd_en !== ((sx % 8 == 6) && (sx < 632))) begin
        errors++; $display("FAIL fetch_pat sx=%0d got %b want %b", sx, ram_rd_en, (sx % 8 == 6) && (sx < 632));
      end
      if (sx == 630) begin
        checks++;
        if (ram_addr !== 13'd239) begin
          errors++; $display("FAIL fetch_last addr got %0d want 239", ram_addr);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (code_o !== 4'hC || px_o !== 3'd7) begin
      errors++; $display("FAIL last_px got code=%h px=%0d want C 7", code_o, px_o);
    end
    de = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (code_o !== 4'hC || valid_o !== 1'b0) begin
      errors++; $display("FAIL blank_hold got code=%h v=%b want C 0", code_o, valid_o);
    end
  endtask

  task automatic test_midline_reset();
    line_start = 1'b1; next_y = 10'd24;
    @(negedge clk);
    line_start = 1'b0;
    repeat (2) @(negedge clk);
    de = 1'b1; sy_in = 10'd24;
    for (int sx = 0; sx <= 20; sx++) begin
      sx_in = 10'(sx);
      @(negedge clk);
    end
    rst = 1'b1; wr_req = 1'b1; wr_addr = 13'd7; wr_code = 4'd2;
    #1;
    checks++;
    if ({valid_o, code_o, ram_rd_en, ram_we, wr_ack} !== 8'd0) begin
      errors++; $display("FAIL midline_rst got %b want 0", {valid_o, code_o, ram_rd_en, ram_we, wr_ack});
    end
    @(negedge clk);
    rst = 1'b0; wr_req = 1'b0; sx_in = 10'd21;
    for (int sx = 22; sx <= 44; sx++) begin
      @(negedge clk);
      checks++;
      if (code_o !== 4'h0 || valid_o !== 1'b1) begin
        errors++; $display("FAIL post_rst sx=%0d got code=%h v=%b want 0 1", sx - 1, code_o, valid_o);
      end
      sx_in = 10'(sx);
      #1;
      checks++;
      if (ram_rd_en !== 1'b0) begin
        errors++; $display("FAIL post_rst_fetch sx=%0d got rd=%b want 0", sx, ram_rd_en);
      end
    end
    @(negedge clk);
    de = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_defer();
`ifdef TILE_FETCH_VBLANK_WR_ONLY_EN
    wr_req = 1'b1; wr_addr = 13'd100; wr_code = 4'h6; vblank = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (wr_ack !== 1'b0 || ram_we !== 1'b0) begin
        errors++; $display("FAIL vb_gate[%0d] got ack=%b we=%b want 0 0", i, wr_ack, ram_we);
      end
      @(negedge clk);
    end
    line_start = 1'b1; next_y = 10'd8;
    @(negedge clk);
    line_start = 1'b0; vblank = 1'b1;
`else
    line_start = 1'b1; next_y = 10'd8;
    @(negedge clk);
    line_start = 1'b0;
    wr_req = 1'b1; wr_addr = 13'd100; wr_code = 4'h6;
`endif
    #1;
    checks++;
    if (ram_rd_en !== 1'b1 || wr_ack !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL pre_vs_wr got rd=%b ack=%b we=%b want 1 0 0", ram_rd_en, wr_ack, ram_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({wr_ack, ram_we, ram_rd_en} !== 3'b110 || ram_addr !== 13'd100 || ram_wdata !== 4'h6) begin
      errors++; $display("FAIL wr_after_pre got ack=%b we=%b rd=%b addr=%0d want 1 1 0 100", wr_ack, ram_we, ram_rd_en, ram_addr);
    end
    ref_mem[100] = 4'h6; ref_wv[100] = 1'b1;
    @(negedge clk);
    wr_req = 1'b0; vblank = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_frames();
    cyc_t          sched[$];
    cyc_t          c;
    int            row, y, line_row, a;
    bit            prev_ls, drop_next, exp_rd, exp_ack, exp_we, exp_valid;
    logic [2:0]    exp_px, exp_py;
    logic [3:0]    exp_code;
    logic [AW-1:0] exp_addr;
    int            bad;

    for (int l = 0; l < 6; l++) begin
      row = int'($urandom_range(V - 1, 0));
      y   = row * 8 + int'($urandom_range(7, 0));
      for (int i = 0; i < 2 + int'($urandom_range(5, 0)); i++)
        sched.push_back('{ls: 0, de: 0, vb: (l % 2 == 0), sx: 0, sy: 0, ny: 0, prot: -1});
      sched.push_back('{ls: 1, de: 0, vb: 0, sx: 0, sy: 0, ny: 10'(y), prot: row});
      for (int i = 0; i < 2 + int'($urandom_range(2, 0)); i++)
        sched.push_back('{ls: 0, de: 0, vb: 0, sx: 0, sy: 0, ny: 0, prot: row});
      for (int sx = 0; sx < 640; sx++)
        sched.push_back('{ls: 0, de: 1, vb: 0, sx: 10'(sx), sy: 10'(y), ny: 0, prot: row});
    end
    for (int i = 0; i < 4; i++)
      sched.push_back('{ls: 0, de: 0, vb: 1, sx: 0, sy: 0, ny: 0, prot: -1});

    @(negedge clk);
    rst = 1'b1; de = 1'b0; sx_in = '0; sy_in = '0; line_start = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_valid = 0; exp_px = '0; exp_py = '0; exp_code = '0;
    prev_ls = 0; drop_next = 0; line_row = 0;

    for (int i = 0; i < sched.size(); i++) begin
      c = sched[i];
      @(negedge clk);
      checks++;
      if ({valid_o, px_o, py_o, code_o} !== {exp_valid, exp_px, exp_py, exp_code}) begin
        errors++; $display("FAIL rnd_pix cyc=%0d got v=%b px=%0d py=%0d code=%h want %b %0d %0d %h",
                           i, valid_o, px_o, py_o, code_o, exp_valid, exp_px, exp_py, exp_code);
      end
      if (drop_next) wr_req = 1'b0;
      drop_next = 0;
      if (wr_req && int'(wr_addr) < MAP && int'(wr_addr) / H == c.prot) wr_req = 1'b0;
      if (!wr_req && $urandom_range(4, 0) == 0) begin
        if ($urandom_range(7, 0) == 0) begin
          a = int'($urandom_range(8191, MAP));
        end else begin
          do a = int'($urandom_range(MAP - 1, 0)); while (a / H == c.prot);
        end
        wr_req = 1'b1; wr_addr = AW'(a); wr_code = 4'($urandom);
      end
      line_start = c.ls; de = c.de; vblank = c.vb; sx_in = c.sx; sy_in = c.sy; next_y = c.ny;
      #1;
      exp_rd = prev_ls || (c.de && (c.sx % 8 == 6) && (c.sx / 8 < H - 1));
      exp_addr = prev_ls ? AW'(line_row * H) : AW'(line_row * H + int'(c.sx / 8) + 1);
`ifdef TILE_FETCH_VBLANK_WR_ONLY_EN
      exp_ack = wr_req && !exp_rd && c.vb;
`else
      exp_ack = wr_req && !exp_rd;
`endif
      exp_we = exp_ack && (int'(wr_addr) < MAP);
      checks++;
      if ({ram_rd_en, wr_ack, ram_we} !== {exp_rd, exp_ack, exp_we}) begin
        errors++; $display("FAIL rnd_port cyc=%0d got rd/ack/we=%b want %b", i, {ram_rd_en, wr_ack, ram_we}, {exp_rd, exp_ack, exp_we});
      end
      if (exp_rd || exp_we) begin
        checks++;
        if (ram_addr !== (exp_rd ? exp_addr : wr_addr) || (exp_we && ram_wdata !== wr_code)) begin
          errors++; $display("FAIL rnd_bus cyc=%0d got addr=%0d data=%h want %0d", i, ram_addr, ram_wdata, exp_rd ? exp_addr : wr_addr);
        end
      end
      if (exp_ack) begin
        drop_next = 1;
        if (exp_we) begin
          ref_mem[int'(wr_addr)] = wr_code; ref_wv[int'(wr_addr)] = 1'b1;
        end
      end
      exp_valid = c.de; exp_px = c.sx[2:0]; exp_py = c.sy[2:0];
      if (c.de) exp_code = ref_val(line_row * H + int'(c.sx / 8));
      prev_ls = c.ls;
      if (c.ls) line_row = int'(c.ny / 8);
    end
    @(negedge clk);
    wr_req = 1'b0;
    checks++;
    if ({valid_o, px_o, py_o, code_o} !== {exp_valid, exp_px, exp_py, exp_code}) begin
      errors++; $display("FAIL rnd_tail got code=%h want %h", code_o, exp_code);
    end
    bad = 0;
    for (int k = 0; k < MAP; k++)
      if ((ram_wv[k] ? ram_mem[k] : init_val(k)) !== ref_val(k)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL map_contents got %0d differing tiles want 0", bad);
    end
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_write_free();
    test_prefetch_fetch();
    test_last_tile();
    test_midline_reset();
    test_write_defer();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
